vga_stream_sink: RTL and testbench
==================================

VGA_STREAM_SINK -- requirements
Module: vga_stream_sink

Interface
REQ-001 Parameter HD, 640, active pixels per line.
REQ-002 Parameter HF, 16; HB, 48; HR, 96; these are the horizontal front porch, back porch and retrace, in pixels.
REQ-003 Parameter VD, 480, active lines per frame.
REQ-004 Parameter VF, 10; VB, 33; VR, 2; these are the vertical front porch, back porch and retrace, in lines.
REQ-005 Parameter DW, 12, pixel data width.
REQ-006 Parameter DEPTH, 16, FIFO entries; must be a power of 2.
REQ-007 clk  in  1  pixel clock; one pixel position per cycle.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 si_data  in  DW  incoming pixel.
REQ-010 si_sof  in  1  marks the pixel at frame position (0,0).
REQ-011 si_valid  in  1  producer has a pixel.
REQ-012 si_ready  out  1  sink accepts a pixel this cycle.
REQ-013 hsync, vsync  out  1 each  active-low sync, registered.
REQ-014 video_on  out  1  registered; high when rgb is an active pixel.
REQ-015 rgb  out  DW  registered pixel output.
REQ-016 hcount, vcount  out  11 each  current timing counter values (unregistered view of the counter registers).
REQ-017 sync_err  out  1  one-cycle pulse on any stream/timing mismatch.
REQ-018 level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 The block shall define HT=HD+HF+HB+HR and VT=VD+VF+VB+VR.
REQ-020 hcount shall increment every cycle and wrap HT-1->0; vcount shall increment when hcount wraps, and wrap VT-1->0.
REQ-021 Combinational pixel-position signals shall be: act = hcount<HD && vcount<VD; hs = hcount in [HD+HF, HD+HF+HR-1]; vs = vcount in [VD+VF, VD+VF+VR-1].
REQ-022 The registers on the cycle after any position shall be: hsync=~hs, vsync=~vs, video_on=act. Latency from position to output is 1 cycle.
REQ-023 A FIFO of DEPTH entries shall store {si_sof,si_data}; a push occurs when si_valid && si_ready.
REQ-024 si_ready shall equal !full; the producer may drop si_valid at any time.
REQ-025 A pop shall require level>0; a push in the same cycle as a pop is allowed and level stays unchanged. A pushed word is not visible at the head until the next cycle (no bypass).
REQ-026 The FSM shall have states SEEK, WAIT, RUN; the reset state is SEEK.
REQ-027 SEEK: if the FIFO is nonempty and head.sof=0, pop and discard the head; if head.sof=1, go to WAIT without popping.
REQ-028 WAIT: when hcount=0, vcount=0 and head.sof=1, pop the head, register rgb=head.data, and go to RUN. Otherwise hold.
REQ-029 RUN: on cycles with act=1, the block shall check the rules below in priority order.
  - (a) FIFO empty: this is underrun; rgb<=0, pulse sync_err, go to SEEK.
  - (b) Position (0,0) and head.sof=0: rgb<=0, pulse sync_err, go to SEEK, do not pop.
  - (c) Position not (0,0) and head.sof=1: this is an early frame start; rgb<=0, pulse sync_err, go to WAIT, do not pop.
  - (d) Otherwise pop and set rgb<=head.data.
REQ-030 RUN on cycles with act=0 shall never pop.
REQ-031 rgb shall be 0 whenever the registered video_on is 0, and in any state other than RUN or the WAIT->RUN pop.
REQ-032 sync_err shall be low on all cycles other than those named in REQ-029.

Reset
REQ-033 While reset_n=0 the outputs shall be: hcount=vcount=0, FIFO empty (level=0), state SEEK, hsync=vsync=1, video_on=0, rgb=0, sync_err=0.
REQ-034 si_ready shall be 1 both while reset_n=0 and after release, because the FIFO is empty. Pushes are ignored while reset_n=0.
REQ-035 Reset asserted mid-frame shall apply REQ-033 immediately and flush the FIFO contents.
REQ-036 On release, counting shall restart at (0,0) on the first clk edge.

Verification (small timing: HD=8,HF=1,HB=1,HR=2 giving HT=12; VD=4,VF=VB=VR=1 giving VT=7; DEPTH=4)
REQ-037 Timing scenario: free run with no input -> hsync low for hcount 9..10 and vsync low for vcount 5, each seen 1 cycle later; 84-cycle frame period; video_on never high; rgb=0; no sync_err.
REQ-038 Aligned stream scenario: drive a 32-pixel frame with values 1..32, sof on value 1 -> output shows 1..32 in raster order with video_on=1, each 1 cycle after its position; no sync_err.
REQ-039 Seek scenario: drive 3 junk pixels (sof=0), then an aligned frame -> junk is discarded; first displayed pixel is the sof pixel at (0,0); no sync_err.
REQ-040 Underrun scenario: stop si_valid after 10 pixels of a frame -> sync_err pulses once, at position (2,1); rgb=0 for the rest of the frame; state SEEK.
REQ-041 Early-sof scenario: assert sof on pixel 5 of a running frame -> a single sync_err pulse at (4,0); display resumes at the next (0,0) with that sof pixel.
REQ-042 Full/reset scenario: push with no pop while in SEEK with sof=1 at the head -> si_ready drops when level=4. Pulse reset_n=0 at that point -> level=0, si_ready=1, hcount=0.

Source files
------------

// File: rtl/vga_stream_sink.sv
// VGA timing generator fed by a valid/ready pixel stream through a small FIFO; sof realigns the stream to (0,0).
// Sync/video_on/rgb lag the counter position by 1 cycle; si_ready drops only while the FIFO is full.
module vga_stream_sink #(
  parameter int HD    = 640,
  parameter int HF    = 16,
  parameter int HB    = 48,
  parameter int HR    = 96,
  parameter int VD    = 480,
  parameter int VF    = 10,
  parameter int VB    = 33,
  parameter int VR    = 2,
  parameter int DW    = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DW-1:0]            si_data,
  input  logic                     si_sof,
  input  logic                     si_valid,
  output logic                     si_ready,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     video_on,
  output logic [DW-1:0]            rgb,
  output logic [10:0]              hcount,
  output logic [10:0]              vcount,
  output logic                     sync_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int AW = $clog2(DEPTH);

  localparam logic [10:0] H_LAST   = 11'(HT - 1);
  localparam logic [10:0] V_LAST   = 11'(VT - 1);
  localparam logic [10:0] H_ACT    = 11'(HD);
  localparam logic [10:0] V_ACT    = 11'(VD);
  localparam logic [10:0] HS_BEG   = 11'(HD + HF);
  localparam logic [10:0] HS_END   = 11'(HD + HF + HR - 1);
  localparam logic [10:0] VS_BEG   = 11'(VD + VF);
  localparam logic [10:0] VS_END   = 11'(VD + VF + VR - 1);
  localparam logic [10:0] CNT_ONE  = 11'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic          sof;
    logic [DW-1:0] data;
  } pix_t;

  typedef enum logic [1:0] {SEEK, WAIT, RUN} state_t;

  state_t        state;
  pix_t          mem [DEPTH];
  pix_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, empty, full;
  logic          act, hs, vs, at_origin;

  // Raster position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_ONE;
    end else begin
      hcount <= hcount + CNT_ONE;
    end
  end

  assign act       = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs        = (hcount >= HS_BEG) && (hcount <= HS_END);
  assign vs        = (vcount >= VS_BEG) && (vcount <= VS_END);
  assign at_origin = (hcount == '0) && (vcount == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      hsync    <= ~hs;
      vsync    <= ~vs;
      video_on <= act;
    end
  end

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign si_ready = ~full;
  assign push     = si_valid && si_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sof: si_sof, data: si_data};
  end

  // Resetting the pointers and level is what flushes the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // In RUN a pixel is consumed only when its sof flag agrees with being at (0,0)
  always_comb begin
    pop = 1'b0;
    case (state)
      SEEK:    pop = !empty && !head.sof;
      WAIT:    pop = at_origin && !empty && head.sof;
      RUN:     pop = act && !empty && (at_origin == head.sof);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEEK;
      rgb      <= '0;
      sync_err <= 1'b0;
    end else begin
      rgb      <= '0;
      sync_err <= 1'b0;
      case (state)
        SEEK: if (!empty && head.sof) state <= WAIT;
        WAIT: if (pop) begin
          rgb   <= head.data;
          state <= RUN;
        end
        RUN: if (act) begin
          if (empty) begin
            sync_err <= 1'b1;
            state    <= SEEK;
          end else if (at_origin && !head.sof) begin
            sync_err <= 1'b1;
            state    <= SEEK;
          end else if (!at_origin && head.sof) begin
            sync_err <= 1'b1;
            state    <= WAIT;
          end else begin
            rgb <= head.data;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_stream_sink.sv
// Bench for vga_stream_sink on a 12x7 raster with a 4-deep FIFO: timing table, directed stream cases, random stream.
module tb_vga_stream_sink;
  localparam int HD = 8, HF = 1, HB = 1, HR = 2;
  localparam int VD = 4, VF = 1, VB = 1, VR = 1;
  localparam int DW = 12, DEPTH = 4;
  localparam int HT = 12, VT = 7;
  localparam int HUNT = 0, ARMED = 1, SHOW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] si_data = '0;
  logic          si_sof = 1'b0;
  logic          si_valid = 1'b0;
  logic          si_ready, hsync, vsync, video_on, sync_err;
  logic [DW-1:0] rgb;
  logic [10:0]   hcount, vcount;
  logic [2:0]    level;

  vga_stream_sink #(.HD(HD), .HF(HF), .HB(HB), .HR(HR), .VD(VD), .VF(VF), .VB(VB), .VR(VR),
                    .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .si_data(si_data), .si_sof(si_sof), .si_valid(si_valid),
    .si_ready(si_ready), .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
    .hcount(hcount), .vcount(vcount), .sync_err(sync_err), .level(level));

  always #5 clk = ~clk;

  typedef struct packed { logic sof; logic [DW-1:0] data; } px_t;
  typedef struct { int n; int hc; int vc; logic hs; logic vs; logic von; } tvec_t;

  int compared = 0, mismatched = 0;
  int t, mode;
  bit gaps;
  px_t mq[$], src[$];
  logic e_hsync, e_vsync, e_von, e_err;
  logic [DW-1:0] e_rgb;
  logic [DW-1:0] disp[$];
  int disp_t[$], err_h[$], err_v[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, got, exp, t);
    end
  endtask

  task automatic add_px(input logic s, input int d);
    src.push_back('{sof: s, data: DW'(d)});
  endtask

  task automatic clear_capture();
    disp.delete(); disp_t.delete(); err_h.delete(); err_v.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; si_valid = 1'b1; si_sof = 1'b1; si_data = 'h5a5;
    @(posedge clk); #1;
    chk("rst_hcount", hcount, 0);   chk("rst_vcount", vcount, 0);
    chk("rst_level", level, 0);     chk("rst_ready", si_ready, 1);
    chk("rst_hsync", hsync, 1);     chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0); chk("rst_rgb", rgb, 0);
    chk("rst_sync_err", sync_err, 0);
    @(posedge clk); #1;
    chk("rst_push_ignored", level, 0);
    reset_n = 1'b1; si_valid = 1'b0; si_sof = 1'b0; si_data = '0;
    mq.delete(); src.delete(); mode = HUNT; t = 0; gaps = 0;
    clear_capture();
  endtask

  // One pixel clock: drive, check counters/FIFO view, advance the model, check registered outputs.
  task automatic cycle();
    int h, v;
    logic drive, act, origin, popit, pushed;
    h = t % HT;
    v = (t / HT) % VT;
    drive = (src.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    si_valid = drive;
    si_sof   = drive ? src[0].sof : 1'b0;
    si_data  = drive ? src[0].data : '0;
    #1;
    chk("hcount", hcount, h);
    chk("vcount", vcount, v);
    chk("level", level, mq.size());
    chk("si_ready", si_ready, mq.size() < DEPTH);
    act    = (h < HD) && (v < VD);
    origin = (h == 0) && (v == 0);
    e_hsync = !(h >= HD + HF && h < HD + HF + HR);
    e_vsync = !(v >= VD + VF && v < VD + VF + VR);
    e_von = act; e_rgb = '0; e_err = 1'b0; popit = 1'b0;
    if (mode == HUNT) begin
      if (mq.size() > 0) begin
        if (mq[0].sof) mode = ARMED;
        else popit = 1'b1;
      end
    end else if (mode == ARMED) begin
      if (origin && mq.size() > 0 && mq[0].sof) begin
        popit = 1'b1; e_rgb = mq[0].data; mode = SHOW;
      end
    end else if (act) begin
      if (mq.size() == 0) begin
        e_err = 1'b1; mode = HUNT;
      end else if (origin != mq[0].sof) begin
        e_err = 1'b1; mode = origin ? HUNT : ARMED;
      end else begin
        popit = 1'b1; e_rgb = mq[0].data;
      end
    end
    pushed = drive && (mq.size() < DEPTH);
    if (popit) void'(mq.pop_front());
    if (pushed) begin
      mq.push_back(src[0]);
      void'(src.pop_front());
    end
    @(posedge clk); #1;
    t++;
    chk("hsync", hsync, e_hsync);
    chk("vsync", vsync, e_vsync);
    chk("video_on", video_on, e_von);
    chk("rgb", rgb, e_rgb);
    chk("sync_err", sync_err, e_err);
    if (video_on && rgb != '0) begin disp.push_back(rgb); disp_t.push_back(t); end
    if (sync_err) begin err_h.push_back(h); err_v.push_back(v); end
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic chk_disp_seq(input string name, input int first, input int n);
    chk({name, "_count"}, disp.size(), n);
    for (int k = 0; k < disp.size() && k < n; k++) chk({name, "_pix"}, disp[k], first + k);
  endtask

  tvec_t tvec[14];

  initial begin
    tvec[0]  = '{1,  1,  0, 1, 1, 1};
    tvec[1]  = '{8,  8,  0, 1, 1, 1};
    tvec[2]  = '{9,  9,  0, 1, 1, 0};
    tvec[3]  = '{10, 10, 0, 0, 1, 0};
    tvec[4]  = '{11, 11, 0, 0, 1, 0};
    tvec[5]  = '{12, 0,  1, 1, 1, 0};
    tvec[6]  = '{13, 1,  1, 1, 1, 1};
    tvec[7]  = '{60, 0,  5, 1, 1, 0};
    tvec[8]  = '{61, 1,  5, 1, 0, 0};
    tvec[9]  = '{72, 0,  6, 1, 0, 0};
    tvec[10] = '{73, 1,  6, 1, 1, 0};
    tvec[11] = '{83, 11, 6, 0, 1, 0};
    tvec[12] = '{84, 0,  0, 1, 1, 0};
    tvec[13] = '{85, 1,  0, 1, 1, 1};

    // Free-running timing with no input
    do_reset();
    for (int i = 0; i < 14; i++) begin
      while (t < tvec[i].n) cycle();
      chk("tbl_hcount", hcount, tvec[i].hc);
      chk("tbl_vcount", vcount, tvec[i].vc);
      chk("tbl_hsync", hsync, tvec[i].hs);
      chk("tbl_vsync", vsync, tvec[i].vs);
      chk("tbl_video_on", video_on, tvec[i].von);
    end
    chk("idle_no_pixels", disp.size(), 0);
    chk("idle_no_err", err_h.size(), 0);

    // Aligned frame 1..32: waits out frame 0, shows in frame 1
    do_reset();
    for (int k = 1; k <= 32; k++) add_px(k == 1, k);
    cycles(167);
    chk_disp_seq("aligned", 1, 32);
    chk("aligned_errs", err_h.size(), 0);
    if (disp_t.size() == 32) begin
      chk("aligned_first_t", disp_t[0], 85);
      chk("aligned_last_t", disp_t[31], 128);
    end

    // Three junk pixels ahead of the frame are discarded
    do_reset();
    for (int k = 0; k < 3; k++) add_px(1'b0, 'ha0 + k);
    for (int k = 1; k <= 32; k++) add_px(k == 1, k);
    cycles(167);
    chk_disp_seq("seek", 1, 32);
    chk("seek_errs", err_h.size(), 0);
    if (disp_t.size() > 0) chk("seek_first_t", disp_t[0], 85);

    // Stream stops after 10 pixels
    do_reset();
    for (int k = 1; k <= 10; k++) add_px(k == 1, k);
    cycles(167);
    chk_disp_seq("underrun", 1, 10);
    chk("underrun_errs", err_h.size(), 1);
    if (err_h.size() > 0) begin
      chk("underrun_err_h", err_h[0], 2);
      chk("underrun_err_v", err_v[0], 1);
    end
    chk("underrun_mode_seek", mode, HUNT);

    // sof on pixel 5 mid-frame; display resumes with it at the next (0,0)
    do_reset();
    for (int k = 1; k <= 36; k++) add_px(k == 1 || k == 5, k);
    cycles(251);
    chk_disp_seq("early_sof", 1, 36);
    chk("early_errs", err_h.size(), 1);
    if (err_h.size() > 0) begin
      chk("early_err_h", err_h[0], 4);
      chk("early_err_v", err_v[0], 0);
    end
    if (disp_t.size() > 4) chk("early_resume_t", disp_t[4], 169);

    // FIFO fills with nothing popping, then an asynchronous reset mid-frame
    do_reset();
    for (int k = 1; k <= 6; k++) add_px(k == 1, k);
    cycles(6);
    chk("full_level", level, 4);
    chk("full_ready", si_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_ready", si_ready, 1);
    chk("arst_hcount", hcount, 0);
    chk("arst_video_on", video_on, 0);
    do_reset();
    cycles(3);

    // Random stream with gaps, stray sofs and truncated frames
    do_reset();
    gaps = 1;
    for (int k = 0; k < 600; k++)
      add_px((k % 32 == 0) || ($urandom_range(0, 60) == 0), $urandom_range(1, 4095));
    cycles(1500);
    gaps = 0;
    src.delete();
    for (int k = 0; k < 160; k++) add_px(k % 32 == 0, $urandom_range(1, 4095));
    cycles(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end
endmodule
